// File: rtl/csr_commit_sequencer.sv
// csr_commit_sequencer
//
// Commit-side responder between the write-back stage and the CSR register
// file. A CSR op (CSRRW/RS/RC or ERET) arriving at commit is latched and
// forwarded to the CSR file with a req/resp handshake. While the op is
// outstanding the control unit is told to stall IF..EXE. The outcome is
// reported as exactly one single-cycle pulse: read data for rd write-back,
// an ERET redirect, or a CSR exception with its trap vector.
//
// Ports
//   clk_i, rst_i           clock (rising edge), asynchronous active-high reset
//   wb_valid_i             valid instruction at commit
//   wb_csr_op_i            0 NONE, 1 RW, 2 RS, 3 RC, 4 ERET, 5-7 reserved
//   wb_csr_addr_i          CSR address
//   wb_csr_wdata_i         rs1 / immediate operand
//   csrf_req_valid_o       request strobe to the CSR file (held until ready)
//   csrf_req_ready_i       CSR file accepts the request
//   csrf_req_op_o          latched op
//   csrf_req_addr_o        latched address
//   csrf_req_wdata_o       latched operand
//   csrf_resp_valid_i      CSR file response strobe
//   csrf_resp_rdata_i      old CSR value
//   csrf_resp_illegal_i    access illegal / privilege fault
//   csrf_resp_evec_i       target PC for ERET or trap
//   csr_stall_o            stall IF..EXE while the op is outstanding
//   csr_eret_o             one-cycle pulse: ERET completed
//   csr_exception_o        one-cycle pulse: CSR exception
//   csr_evec_o             jump target, valid with eret/exception pulse
//   csr_rdata_o            read data for rd write-back
//   csr_rdata_valid_o      one-cycle pulse: csr_rdata_o valid
module csr_commit_sequencer #(
  parameter int              XLEN     = 64,
  parameter int              TIMEOUT  = 64,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(64'h0000_0100)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wb_valid_i,
  input  logic [2:0]      wb_csr_op_i,
  input  logic [11:0]     wb_csr_addr_i,
  input  logic [XLEN-1:0] wb_csr_wdata_i,
  output logic            csrf_req_valid_o,
  input  logic            csrf_req_ready_i,
  output logic [2:0]      csrf_req_op_o,
  output logic [11:0]     csrf_req_addr_o,
  output logic [XLEN-1:0] csrf_req_wdata_o,
  input  logic            csrf_resp_valid_i,
  input  logic [XLEN-1:0] csrf_resp_rdata_i,
  input  logic            csrf_resp_illegal_i,
  input  logic [XLEN-1:0] csrf_resp_evec_i,
  output logic            csr_stall_o,
  output logic            csr_eret_o,
  output logic            csr_exception_o,
  output logic [XLEN-1:0] csr_evec_o,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_rdata_valid_o
);

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_RW   = 3'd1;
  localparam logic [2:0] OP_RS   = 3'd2;
  localparam logic [2:0] OP_RC   = 3'd3;
  localparam logic [2:0] OP_ERET = 3'd4;

  // One spare count beyond TIMEOUT: after a grant on the last allowed REQ
  // cycle the counter reaches TIMEOUT while in WAIT.
  localparam int               CNT_W    = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [11:0]       addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [XLEN-1:0]   evec_q, evec_d;
  logic              exc_q, exc_d;

  logic start;
  logic reserved_op;
  logic timeout_hit;
  logic in_resp;

  assign start       = wb_valid_i && (wb_csr_op_i != OP_NONE);
  assign reserved_op = (wb_csr_op_i > OP_ERET);
  // Counter never stops below CNT_LAST in REQ/WAIT, so >= only matters for
  // the extra WAIT cycle that follows a last-moment grant.
  assign timeout_hit = (cnt_q >= CNT_LAST);

  // ---------------------------------------------------------------------
  // Next-state and capture logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    evec_d  = evec_q;
    exc_d   = exc_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = wb_csr_op_i;
          addr_d  = wb_csr_addr_i;
          wdata_d = wb_csr_wdata_i;
          cnt_d   = '0;
          rdata_d = '0;
          if (reserved_op) begin
            // Reserved encodings never reach the CSR file.
            exc_d   = 1'b1;
            evec_d  = TRAP_VEC;
            state_d = S_RESP;
          end else begin
            exc_d   = 1'b0;
            evec_d  = '0;
            state_d = S_REQ;
          end
        end
      end

      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (csrf_req_ready_i) begin
          state_d = S_WAIT;
        end else if (timeout_hit) begin
          exc_d   = 1'b1;
          evec_d  = TRAP_VEC;
          state_d = S_RESP;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (csrf_resp_valid_i) begin
          rdata_d = csrf_resp_rdata_i;
          evec_d  = csrf_resp_evec_i;
          exc_d   = csrf_resp_illegal_i;
          state_d = S_RESP;
        end else if (timeout_hit) begin
          exc_d   = 1'b1;
          evec_d  = TRAP_VEC;
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State and latched fields
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      evec_q  <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      evec_q  <= evec_d;
      exc_q   <= exc_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: decoded from registered state and fields only, except the
  // stall, which must already be high in the commit cycle itself.
  // ---------------------------------------------------------------------
  assign in_resp = (state_q == S_RESP);

  assign csr_stall_o      = ((state_q == S_IDLE) && start)
                         || (state_q == S_REQ)
                         || (state_q == S_WAIT);
  assign csrf_req_valid_o = (state_q == S_REQ);
  assign csrf_req_op_o    = op_q;
  assign csrf_req_addr_o  = addr_q;
  assign csrf_req_wdata_o = wdata_q;

  assign csr_exception_o   = in_resp && exc_q;
  assign csr_eret_o        = in_resp && !exc_q && (op_q == OP_ERET);
  assign csr_rdata_valid_o = in_resp && !exc_q && (op_q inside {OP_RW, OP_RS, OP_RC});
  assign csr_evec_o        = (csr_exception_o || csr_eret_o) ? evec_q : '0;
  assign csr_rdata_o       = csr_rdata_valid_o ? rdata_q : '0;

endmodule

// File: tb/tb_csr_commit_sequencer.sv
// Testbench for csr_commit_sequencer: directed scenarios plus randomized
// transactions, checked against a transaction-level timing/result model.
module tb_csr_commit_sequencer;

  localparam int          XLEN     = 64;
  localparam int          TIMEOUT  = 64;
  localparam logic [63:0] TRAP_VEC = 64'h0000_0100;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [2:0]  wb_op;
  logic [11:0] wb_addr;
  logic [63:0] wb_wdata;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [11:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_illegal;
  logic [63:0] resp_evec;
  logic        stall;
  logic        eret;
  logic        exc;
  logic [63:0] evec;
  logic [63:0] rdata;
  logic        rvalid;

  int n_checks = 0;
  int n_errors = 0;
  bit tb_busy  = 1'b0;

  csr_commit_sequencer #(
    .XLEN    (XLEN),
    .TIMEOUT (TIMEOUT),
    .TRAP_VEC(TRAP_VEC)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .wb_valid_i         (wb_valid),
    .wb_csr_op_i        (wb_op),
    .wb_csr_addr_i      (wb_addr),
    .wb_csr_wdata_i     (wb_wdata),
    .csrf_req_valid_o   (req_valid),
    .csrf_req_ready_i   (req_ready),
    .csrf_req_op_o      (req_op),
    .csrf_req_addr_o    (req_addr),
    .csrf_req_wdata_o   (req_wdata),
    .csrf_resp_valid_i  (resp_valid),
    .csrf_resp_rdata_i  (resp_rdata),
    .csrf_resp_illegal_i(resp_illegal),
    .csrf_resp_evec_i   (resp_evec),
    .csr_stall_o        (stall),
    .csr_eret_o         (eret),
    .csr_exception_o    (exc),
    .csr_evec_o         (evec),
    .csr_rdata_o        (rdata),
    .csr_rdata_valid_o  (rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The control unit never presents a new CSR op while one is outstanding.
  always @(posedge clk) begin
    if (wb_valid && wb_op != 3'd0)
      assert (!tb_busy) else $error("start driven while sequencer busy");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_resp_noise();
    resp_valid   = 1'($urandom);
    resp_rdata   = {$urandom, $urandom};
    resp_illegal = 1'($urandom);
    resp_evec    = {$urandom, $urandom};
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_stall"}, 64'(stall), 64'd0);
    check_eq({tag, "_reqv"},  64'(req_valid), 64'd0);
    check_eq({tag, "_reqf"},  64'({req_op, req_addr}), 64'd0);
    check_eq({tag, "_reqwd"}, req_wdata, 64'd0);
    check_eq({tag, "_pulse"}, 64'({exc, eret, rvalid}), 64'd0);
    check_eq({tag, "_evec"},  evec, 64'd0);
    check_eq({tag, "_rdata"}, rdata, 64'd0);
  endtask

  // Idle cycles with non-start commit traffic and stray CSR-file strobes.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      tb_busy   = 1'b0;
      wb_valid  = 1'($urandom);
      wb_op     = wb_valid ? 3'd0 : 3'($urandom);
      wb_addr   = 12'($urandom);
      wb_wdata  = {$urandom, $urandom};
      req_ready = 1'($urandom);
      drive_resp_noise();
      @(negedge clk);
      check_eq("idle_stall", 64'(stall), 64'd0);
      check_eq("idle_reqv", 64'(req_valid), 64'd0);
      check_eq("idle_pulse", 64'({exc, eret, rvalid}), 64'd0);
    end
  endtask

  // One CSR op. d_r: REQ cycles without ready before the grant cycle;
  // d_w: WAIT cycles without response before the response cycle.
  task automatic run_txn(input logic [2:0] op, input logic [11:0] addr,
                         input logic [63:0] wd, input int d_r, input int d_w,
                         input logic [63:0] rd, input logic ill,
                         input logic [63:0] ev, input bit noise);
    int L, nreq, kresp, wmax;
    bit tmo, reserved;
    logic [2:0]  exp_pulse;
    logic [63:0] exp_evec, exp_rdata;

    // Model: L = cycles spent in REQ+WAIT; result appears on cycle L+1.
    reserved = (op >= 3'd5);
    tmo      = 1'b0;
    if (reserved) begin
      nreq = 0;
      L    = 0;
    end else if (d_r > TIMEOUT - 1) begin
      nreq = TIMEOUT;
      L    = TIMEOUT;
      tmo  = 1'b1;
    end else begin
      nreq = d_r + 1;
      wmax = TIMEOUT - 2 - d_r;
      if (wmax < 0) wmax = 0;
      if (d_w > wmax) begin
        L   = nreq + wmax + 1;
        tmo = 1'b1;
      end else begin
        L = nreq + d_w + 1;
      end
    end
    kresp     = d_r + 2 + d_w;
    exp_evec  = 64'd0;
    exp_rdata = 64'd0;
    if (reserved || tmo) begin
      exp_pulse = 3'b100;
      exp_evec  = TRAP_VEC;
    end else if (ill) begin
      exp_pulse = 3'b100;
      exp_evec  = ev;
    end else if (op == 3'd4) begin
      exp_pulse = 3'b010;
      exp_evec  = ev;
    end else begin
      exp_pulse = 3'b001;
      exp_rdata = rd;
    end

    // Commit cycle
    @(posedge clk); #1;
    tb_busy   = 1'b0;
    wb_valid  = 1'b1;
    wb_op     = op;
    wb_addr   = addr;
    wb_wdata  = wd;
    req_ready = noise ? 1'($urandom) : 1'b0;
    if (noise) drive_resp_noise(); else resp_valid = 1'b0;
    @(negedge clk);
    check_eq("start_stall", 64'(stall), 64'd1);
    check_eq("start_reqv", 64'(req_valid), 64'd0);
    check_eq("start_pulse", 64'({exc, eret, rvalid}), 64'd0);

    for (int k = 1; k <= L + 1; k++) begin
      @(posedge clk); #1;
      tb_busy  = 1'b1;
      wb_valid = 1'b0;
      wb_op    = 3'($urandom);
      wb_addr  = 12'($urandom);
      wb_wdata = {$urandom, $urandom};
      if (k <= nreq) req_ready = (k == d_r + 1);
      else           req_ready = noise ? 1'($urandom) : 1'b0;
      if (!reserved && k == kresp) begin
        resp_valid   = 1'b1;
        resp_rdata   = rd;
        resp_illegal = ill;
        resp_evec    = ev;
      end else if (noise && (k <= nreq || k == L + 1)) begin
        drive_resp_noise();
      end else begin
        resp_valid   = 1'b0;
        resp_rdata   = {$urandom, $urandom};
        resp_illegal = 1'($urandom);
        resp_evec    = {$urandom, $urandom};
      end
      @(negedge clk);
      check_eq("stall", 64'(stall), 64'(k <= L));
      check_eq("req_valid", 64'(req_valid), 64'(k <= nreq));
      if (k <= nreq) begin
        check_eq("req_op", 64'(req_op), 64'(op));
        check_eq("req_addr", 64'(req_addr), 64'(addr));
        check_eq("req_wdata", req_wdata, wd);
      end
      if (k == L + 1) begin
        check_eq("resp_pulse", 64'({exc, eret, rvalid}), 64'(exp_pulse));
        if (exp_pulse == 3'b001) check_eq("resp_rdata", rdata, exp_rdata);
        else                     check_eq("resp_evec", evec, exp_evec);
      end else begin
        check_eq("busy_pulse", 64'({exc, eret, rvalid}), 64'd0);
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    wb_valid     = 1'b0;
    wb_op        = 3'd0;
    wb_addr      = 12'd0;
    wb_wdata     = 64'd0;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_rdata   = 64'd0;
    resp_illegal = 1'b0;
    resp_evec    = 64'd0;

    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(3);

    // Directed scenarios
    run_txn(3'd1, 12'h300, 64'hA, 0, 1, 64'h1800, 1'b0, 64'h0, 1'b0);
    idle_cycles(1);
    run_txn(3'd4, 12'h000, 64'h0, 0, 0, 64'h0, 1'b0, 64'h8000_0100, 1'b0);
    run_txn(3'd2, 12'hC00, 64'h5, 0, 0, 64'h55, 1'b1, 64'h200, 1'b0);
    idle_cycles(1);
    run_txn(3'd1, 12'h341, 64'h7, 1000, 0, 64'h1, 1'b0, 64'h0, 1'b0);
    run_txn(3'd5, 12'h123, 64'h9, 0, 0, 64'h0, 1'b0, 64'h0, 1'b0);
    run_txn(3'd7, 12'h456, 64'h9, 0, 0, 64'h0, 1'b0, 64'h0, 1'b1);
    // RS with zero operand is still issued
    run_txn(3'd2, 12'h340, 64'h0, 1, 0, 64'hDEAD_BEEF, 1'b0, 64'h0, 1'b1);
    // Timeout boundaries
    run_txn(3'd3, 12'h305, 64'h3, 0, 62, 64'h1234, 1'b0, 64'h0, 1'b1);
    run_txn(3'd3, 12'h305, 64'h3, 0, 63, 64'h1234, 1'b0, 64'h0, 1'b1);
    run_txn(3'd1, 12'h306, 64'h4, 63, 0, 64'h4321, 1'b0, 64'h0, 1'b1);
    run_txn(3'd4, 12'h306, 64'h4, 63, 1, 64'h0, 1'b0, 64'h700, 1'b1);
    run_txn(3'd1, 12'h307, 64'h5, 62, 0, 64'h5555, 1'b0, 64'h0, 1'b1);

    // Reset during WAIT, then a stray response after release
    @(posedge clk); #1;
    tb_busy  = 1'b0;
    wb_valid = 1'b1; wb_op = 3'd1; wb_addr = 12'h305; wb_wdata = 64'hFF;
    req_ready = 1'b0; resp_valid = 1'b0;
    @(posedge clk); #1;
    tb_busy = 1'b1; wb_valid = 1'b0; req_ready = 1'b1;
    @(posedge clk); #1;
    req_ready = 1'b0;
    @(negedge clk);
    check_eq("rstwait_stall", 64'(stall), 64'd1);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; tb_busy = 1'b0;
    @(posedge clk); #1;
    resp_valid = 1'b1; resp_rdata = 64'hABCD; resp_illegal = 1'b0; resp_evec = 64'h999;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_all_zero("post_rst");
      @(posedge clk); #1;
      resp_valid = 1'b0;
    end
    run_txn(3'd1, 12'h300, 64'h11, 0, 0, 64'h22, 1'b0, 64'h0, 1'b0);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      logic [2:0]  op;
      int          d_r, d_w;
      logic [63:0] wd;
      op  = ($urandom_range(0, 9) < 2) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(1, 4));
      d_r = ($urandom_range(0, 7) == 0) ? $urandom_range(56, 70) : $urandom_range(0, 3);
      d_w = ($urandom_range(0, 7) == 0) ? $urandom_range(56, 70) : $urandom_range(0, 3);
      wd  = ($urandom_range(0, 5) == 0) ? 64'd0 : {$urandom, $urandom};
      run_txn(op, 12'($urandom), wd, d_r, d_w, {$urandom, $urandom},
              ($urandom_range(0, 5) == 0), {$urandom, $urandom}, 1'b1);
      idle_cycles($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
